idct_macu: RTL and testbench
============================

# idct_macu

Inverse-DCT multiply-accumulate unit for the JPEG decode path. It is the counterpart of the forward-DCT `macu` in `fdct_zigzag.dct_mod.dct_unit_*`. It accepts a stream of signed dequantised coefficients, each paired with a Q-format cosine constant. Every `TAPS` accepted pairs produce one rounded, range-limited spatial sample. It sits between the coefficient dequantiser and the row/column transpose buffer, which is the mirror image of the encoder's `dct_unit` placement.

## Interface
Parameters:
- `DIN_W`, 12, signed coefficient width
- `COEF_W`, 16, signed cosine constant width, Q(FRAC)
- `FRAC`, 14, fractional bits in `coef`
- `TAPS`, 8, products per output sample (power of two)
- `DOUT_W`, 9, signed output sample width

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  `din`/`coef` pair valid
- `in_ready`  out  1  unit can accept a pair this cycle
- `din`  in  DIN_W  signed coefficient
- `coef`  in  COEF_W  signed cosine constant
- `out_valid`  out  1  `dout` holds a completed sample
- `out_ready`  in  1  downstream consumes `dout`
- `dout`  out  DOUT_W  signed spatial sample

## Operation
- A pair is accepted on any rising edge with `in_valid && in_ready`.
- **Stage 1, `mult_res`:**
  - On accept, `mult_res <= din * coef`, signed, full width `DIN_W+COEF_W`.
  - `mult_vld <= 1`.
  - `mult_last <= (tap_cnt == TAPS-1)`.
- **Tap counter:** `tap_cnt` increments on every accept and wraps from `TAPS-1` to 0.
- **Stage 2, accumulate:**
  - Accumulator width is `ACC_W = DIN_W+COEF_W+log2(TAPS)`. It cannot overflow.
  - For a non-last term: `acc <= acc + mult_res`.
  - For the last term: `sum = acc + mult_res`, then `acc <= 0`, and the output register is loaded with `round(sum)`.
- **Rounding:** `(sum + 2^(FRAC-1)) >>> FRAC`, i.e. arithmetic shift, round-half-up.
- **Range limit:** the rounded value is limited to `DOUT_W` bits, as set under Configuration.
- **Stall:** `stall = mult_vld && mult_last && out_valid && !out_ready`.
  - While stalled, stage 1 and `acc` hold, and `in_ready = 0`.
  - `in_ready = !stall`. This is combinational from `out_ready` by design.
- **Output register:**
  - `out_valid` sets when the last term retires.
  - It clears on `out_valid && out_ready` unless a new last term retires in the same cycle, in which case it stays 1 and `dout` is replaced.
  - `dout` is stable while `out_valid && !out_ready`.
- **Reset values** (async assert at any time, including mid-sample): `mult_res=0`, `mult_vld=0`, `mult_last=0`, `tap_cnt=0`, `acc=0`, `out_valid=0`, `dout=0`. The partial sample is discarded, and the next accepted pair is tap 0.
- `in_ready` is 1 out of reset.

## Timing
- Latency: last pair accepted at edge E0 → `out_valid=1` after E1, i.e. 2 cycles.
- Throughput: one pair per cycle, so one sample per `TAPS` cycles with no backpressure.
- Back-to-back samples: the tap-0 pair of sample N+1 may be accepted on the same edge that sample N's last term retires.
- With `out_ready` tied to 1, the unit never stalls.
- Gaps in `in_valid` only delay retirement. Bubbles propagate, and `mult_vld` drops for one cycle per gap.

## Configuration
- `IDCT_MACU_SAT_EN` defined: the rounded value is clamped to `[-2^(DOUT_W-1), 2^(DOUT_W-1)-1]`, i.e. [-256, 255] at default width.
- Undefined: the rounded value is truncated to its low `DOUT_W` bits (two's-complement wrap). No clamp logic is built.

## Test plan
- **Rounding:** after reset, send `din=1,coef=8192` then seven `din=0,coef=0` → `dout=1`, `out_valid` 2 cycles after the 8th accept.
- **Negative half:** `din=-1,coef=8192` + seven zero pairs → `dout=0` (round-half-up); `din=-3,coef=8192` + zeros → `dout=-1`.
- **Overflow, all 8 pairs `din=100,coef=8192`:** with `IDCT_MACU_SAT_EN` → `dout=255`; without it → `dout=-112`.
- **Backpressure:** send 16 back-to-back pairs with `out_ready=0`.
  - `in_ready` drops when the 16th term reaches stage 1.
  - The first sample holds stable.
  - Raise `out_ready` → both samples delivered in order, with no pair lost.
- **Reset mid-sample:** send 5 pairs `din=50,coef=16384`, pulse `rst_n` low, then send 8 pairs `din=1,coef=16384` → a single output `dout=8`, with no stale contribution.
- **Streaming:** 64 random pairs with random `in_valid` gaps and random `out_ready` → 8 samples, each matching the reference model bit-exactly under both macro settings.

Source files
------------

// File: rtl/idct_macu_if.sv
// Stream bundle for idct_macu: coefficient/constant pairs in, spatial samples out.
//   in_valid/in_ready/din/coef   : input pair handshake
//   out_valid/out_ready/dout     : output sample handshake
// master = producer/consumer side, slave = the MAC unit.
interface idct_macu_if #(
  parameter int unsigned DIN_W  = 12,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned DOUT_W = 9
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DIN_W-1:0]  din;
  logic signed [COEF_W-1:0] coef;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DOUT_W-1:0] dout;

  modport master (
    output in_valid, din, coef, out_ready,
    input  in_ready, out_valid, dout
  );

  modport slave (
    input  in_valid, din, coef, out_ready,
    output in_ready, out_valid, dout
  );
endinterface

// File: rtl/idct_macu.sv
// idct_macu: inverse-DCT multiply-accumulate unit.
// Accumulates TAPS products din*coef (coef in Q(FRAC)), rounds half-up,
// range-limits to DOUT_W bits and presents one sample per TAPS accepted pairs.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : idct_macu_if.slave (in_valid/in_ready/din/coef, out_valid/out_ready/dout)
// Optional feature macro: IDCT_MACU_SAT_EN
//   defined   -> rounded value clamped to the signed DOUT_W range
//   undefined -> rounded value wraps to its low DOUT_W bits
// in_ready is combinational from out_ready by design.
module idct_macu #(
  parameter int unsigned DIN_W  = 12,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned FRAC   = 14,
  parameter int unsigned TAPS   = 8,
  parameter int unsigned DOUT_W = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  idct_macu_if.slave  bus
);

  localparam int unsigned PROD_W = DIN_W + COEF_W;
  localparam int unsigned CNT_W  = $clog2(TAPS);
  localparam int unsigned ACC_W  = PROD_W + CNT_W;

  localparam logic signed [ACC_W-1:0] HALF =
    {{(ACC_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

  logic signed [PROD_W-1:0] mult_res;
  logic                     mult_vld;
  logic                     mult_last;
  logic [CNT_W-1:0]         tap_cnt;
  logic signed [ACC_W-1:0]  acc;
  logic                     out_valid_q;
  logic signed [DOUT_W-1:0] dout_q;

  logic                     stall;
  logic                     accept;
  logic                     retire;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  rounded;
  logic signed [DOUT_W-1:0] dout_next;

  // Only a last term meeting an unconsumed sample blocks the pipe.
  assign stall  = mult_vld && mult_last && out_valid_q && !bus.out_ready;
  assign accept = bus.in_valid && !stall;
  assign retire = mult_vld && mult_last && !stall;

  assign bus.in_ready  = !stall;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;

  // Final sum, round-half-up and range limit.
  always_comb begin
    sum     = acc + ACC_W'(mult_res);
    rounded = (sum + HALF) >>> FRAC;
`ifdef IDCT_MACU_SAT_EN
    begin
      logic signed [ACC_W-1:0] out_max;
      logic signed [ACC_W-1:0] out_min;
      out_max = {{(ACC_W-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
      out_min = {{(ACC_W-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};
      if (rounded > out_max) begin
        dout_next = DOUT_W'(out_max);
      end else if (rounded < out_min) begin
        dout_next = DOUT_W'(out_min);
      end else begin
        dout_next = DOUT_W'(rounded);
      end
    end
`else
    dout_next = rounded[DOUT_W-1:0];
`endif
  end

`ifndef IDCT_MACU_SAT_EN
  // Upper rounded bits are intentionally dropped when wrapping.
  logic unused_rounded_hi;
  assign unused_rounded_hi = ^rounded[ACC_W-1:DOUT_W];
`endif

  // Stage 1: product register and tap counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mult_res  <= '0;
      mult_vld  <= 1'b0;
      mult_last <= 1'b0;
      tap_cnt   <= '0;
    end else if (!stall) begin
      if (accept) begin
        mult_res  <= PROD_W'(bus.din) * PROD_W'(bus.coef);
        mult_vld  <= 1'b1;
        mult_last <= (tap_cnt == LAST_TAP);
        tap_cnt   <= tap_cnt + CNT_W'(1);
      end else begin
        mult_vld  <= 1'b0;
        mult_last <= 1'b0;
      end
    end
  end

  // Stage 2: accumulator, cleared as the last term retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (mult_vld && !stall) begin
      if (mult_last) begin
        acc <= '0;
      end else begin
        acc <= sum;
      end
    end
  end

  // Output register: a retiring sample overrides a same-cycle consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
    end else if (retire) begin
      out_valid_q <= 1'b1;
      dout_q      <= dout_next;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_idct_macu.sv
// Directed and constrained-random bench for idct_macu.
module tb_idct_macu;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_bad;
  bit   rand_rdy;
  logic signed [8:0] got_q[$];
  logic signed [8:0] exp_q[$];

  idct_macu_if bus ();

  idct_macu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every sample whose handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) got_q.push_back(bus.dout);
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [8:0] ref_sample(input longint s);
    longint r;
    logic signed [8:0] o;
    r = (s + 64'sd8192) >>> 14;
`ifdef IDCT_MACU_SAT_EN
    if (r > 255) r = 255;
    else if (r < -256) r = -256;
`endif
    o = 9'(r);
    return o;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  // Present one pair and hold it until it is accepted.
  task automatic send_pair(input int d, input int c);
    bit ok;
    int n;
    bus.in_valid = 1'b1;
    bus.din      = 12'(d);
    bus.coef     = 16'(c);
    n = 0;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      next_cycle();
      n++;
    end while (!ok && n < 300);
    if (!ok) check("accept_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  // Eight pairs with out_ready low; checks latency, value, then consumes.
  task automatic run_sample(input string tag, input int d0, input int c0,
                            input int dr, input longint exp);
    send_pair(d0, c0);
    for (int i = 1; i < 8; i++) send_pair(dr, 0);
    check({tag, "_early_vld"}, longint'(bus.out_valid), 0);
    next_cycle();
    check({tag, "_vld"}, longint'(bus.out_valid), 1);
    check({tag, "_dout"}, longint'(bus.dout), exp);
    bus.out_ready = 1'b1;
    next_cycle();
    bus.out_ready = 1'b0;
    check({tag, "_consumed"}, longint'(bus.out_valid), 0);
  endtask

  initial begin
    longint acc_s;
    int d;
    int c;
    int n;
    n_chk     = 0;
    n_bad     = 0;
    rand_rdy  = 1'b0;
    rst_n     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.din       = '0;
    bus.coef      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_dout", longint'(bus.dout), 0);
    check("rst_in_ready", longint'(bus.in_ready), 1);
    rst_n = 1'b1;
    next_cycle();

    // Rounding and negative half-way cases.
    run_sample("round_pos", 1, 8192, 0, 1);
    run_sample("round_neg_half", -1, 8192, 0, 0);
    run_sample("round_neg3", -3, 8192, 0, -1);

    // Overflow: eight 100*0.5 terms -> 400.
    send_pair(100, 8192);
    for (int i = 1; i < 8; i++) send_pair(100, 8192);
    next_cycle();
`ifdef IDCT_MACU_SAT_EN
    check("ovf_dout", longint'(bus.dout), 255);
`else
    check("ovf_dout", longint'(bus.dout), -112);
`endif
    bus.out_ready = 1'b1;
    next_cycle();
    bus.out_ready = 1'b0;

    // Backpressure: sample A = 36, sample B = -18.
    got_q.delete();
    for (int k = 1; k <= 8; k++) send_pair(k, 16384);
    for (int k = 1; k <= 8; k++) send_pair(-k, 8192);
    check("bp_in_ready_low", longint'(bus.in_ready), 0);
    check("bp_hold_vld", longint'(bus.out_valid), 1);
    check("bp_hold_a", longint'(bus.dout), 36);
    repeat (4) next_cycle();
    check("bp_still_a", longint'(bus.dout), 36);
    check("bp_still_stalled", longint'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    repeat (4) next_cycle();
    check("bp_count", longint'(got_q.size()), 2);
    if (got_q.size() == 2) begin
      check("bp_first", longint'(got_q[0]), 36);
      check("bp_second", longint'(got_q[1]), -18);
    end
    check("bp_drained", longint'(bus.out_valid), 0);

    // Reset mid-sample discards the partial sum and the tap position.
    for (int i = 0; i < 5; i++) send_pair(50, 16384);
    rst_n = 1'b0;
    #2;
    check("midrst_vld", longint'(bus.out_valid), 0);
    check("midrst_in_ready", longint'(bus.in_ready), 1);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    got_q.delete();
    for (int i = 0; i < 8; i++) send_pair(1, 16384);
    repeat (5) next_cycle();
    check("midrst_count", longint'(got_q.size()), 1);
    if (got_q.size() >= 1) check("midrst_dout", longint'(got_q[0]), 8);

    // Streaming with random gaps and random out_ready.
    got_q.delete();
    exp_q.delete();
    rand_rdy = 1'b1;
    for (int s = 0; s < 8; s++) begin
      acc_s = 0;
      for (int t = 0; t < 8; t++) begin
        d = int'($urandom_range(0, 4095)) - 2048;
        c = int'($urandom_range(0, 65535)) - 32768;
        acc_s += longint'(d) * longint'(c);
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 2)) next_cycle();
        end
        send_pair(d, c);
      end
      exp_q.push_back(ref_sample(acc_s));
    end
    n = 0;
    while (got_q.size() < 8 && n < 500) begin
      next_cycle();
      n++;
    end
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) next_cycle();
    check("stream_count", longint'(got_q.size()), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < got_q.size()) check($sformatf("stream_s%0d", i), longint'(got_q[i]), longint'(exp_q[i]));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
